sequence_detector_prog: RTL and testbench

- Runtime-programmable serial bit-pattern detector.
- Generalises the fixed 11011 detector:
  - pattern of up to N bits, loadable at run time;
  - selectable overlapping / non-overlapping matching;
  - input valid qualifier;
  - saturating match counter.
- Sits on a one-bit serial stream and flags each completed occurrence of the programmed pattern with a registered one-cycle pulse on `dout`.
- Out of reset it behaves as an overlapping 11011 detector.

---
 rtl/sequence_detector_prog.sv | 106 ++++++++++
 tb/tb_sequence_detector_prog.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sequence_detector_prog.sv
// Runtime-programmable serial pattern detector with overlap control, a din_valid
// qualifier and a saturating match counter. Out of reset it detects 11011, overlapping.
module sequence_detector_prog #(
  parameter int           N           = 8,
  parameter int           CNT_W       = 16,
  parameter logic [N-1:0] DEFAULT_PAT = 'b0001_1011,
  parameter int           DEFAULT_LEN = 5,
  parameter bit           DEFAULT_OVL = 1'b1,
  localparam int          LW          = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             cfg_load,
  input  logic [N-1:0]     pat_in,
  input  logic [LW-1:0]    pat_len,
  input  logic             ovl_in,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0]     hist_q, hist_d, hist_n;
  logic [LW-1:0]    fill_q, fill_d, fill_n;
  logic [N-1:0]     pat_q, pat_d;
  logic [LW-1:0]    len_q, len_d;
  logic             ovl_q, ovl_d;
  logic             dout_q, dout_d;
  logic             cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     len_mask;
  logic             cfg_ok;
  logic             match;

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    cnt_d     = cnt_q;
    cfg_err_d = 1'b0;
    match     = 1'b0;
    cfg_ok    = cfg_load && (pat_len != '0) && (pat_len <= LW'(N));
    hist_n    = {hist_q[N-2:0], din};
    fill_n    = (fill_q >= LW'(N)) ? LW'(N) : fill_q + LW'(1);
    for (int i = 0; i < N; i++) begin
      len_mask[i] = (i < int'(len_q));
    end

    if (cfg_ok) begin
      // A new config restarts matching from an empty history; the current bit is dropped.
      pat_d  = pat_in;
      len_d  = pat_len;
      ovl_d  = ovl_in;
      hist_d = '0;
      fill_d = '0;
    end else begin
      // A rejected config still lets the data bit through.
      cfg_err_d = cfg_load;
      if (din_valid) begin
        match  = (fill_n >= len_q) && (((hist_n ^ pat_q) & len_mask) == '0);
        hist_d = hist_n;
        fill_d = (match && !ovl_q) ? '0 : fill_n;
      end
    end

    dout_d = match;
    if (cnt_clr) begin
      cnt_d = match ? CNT_W'(1) : '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pat_q     <= DEFAULT_PAT;
      len_q     <= LW'(DEFAULT_LEN);
      ovl_q     <= DEFAULT_OVL;
      dout_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      dout_q    <= dout_d;
      cfg_err_q <= cfg_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign dout      = dout_q;
  assign match_cnt = cnt_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_sequence_detector_prog.sv
// Directed bench for sequence_detector_prog: a default instance plus a CNT_W=2 instance
// sharing the same stimulus, used for counter saturation.
module tb_sequence_detector_prog;

  localparam int N  = 8;
  localparam int LW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic          cfg_load = 1'b0;
  logic [N-1:0]  pat_in = '0;
  logic [LW-1:0] pat_len = '0;
  logic          ovl_in = 1'b0;
  logic          cnt_clr = 1'b0;

  logic          dout, cfg_err;
  logic [15:0]   match_cnt;
  logic          dout_c, cfg_err_c;
  logic [1:0]    match_cnt_c;

  int checks = 0;
  int failures = 0;

  sequence_detector_prog dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .pat_in(pat_in), .pat_len(pat_len), .ovl_in(ovl_in), .cnt_clr(cnt_clr),
    .dout(dout), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  sequence_detector_prog #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .pat_in(pat_in), .pat_len(pat_len), .ovl_in(ovl_in), .cnt_clr(cnt_clr),
    .dout(dout_c), .match_cnt(match_cnt_c), .cfg_err(cfg_err_c)
  );

  // Clock
  always #5 clk = ~clk;

  // Drivers: apply inputs, take one edge, settle 1ns past it.
  task automatic step(input logic d, input logic v);
    din = d;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic do_cfg(input logic [N-1:0] p, input logic [LW-1:0] l, input logic o,
                        input logic d, input logic v);
    cfg_load = 1'b1;
    pat_in = p;
    pat_len = l;
    ovl_in = o;
    step(d, v);
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dout !== 1'b0) begin failures++; $display("FAIL reset_dout: got %b want 0", dout); end
    checks++; if (match_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", match_cnt); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", cfg_err); end
    checks++; if (match_cnt_c !== 2'd0) begin failures++; $display("FAIL reset_cnt_c: got %0d want 0", match_cnt_c); end
  endtask

  task automatic test_default_overlap();
    logic [10:0] bits = 11'b11011011011;
    logic [10:0] exp  = 11'b00001001001;
    do_reset();
    for (int i = 10; i >= 0; i--) begin
      step(bits[i], 1'b1);
      checks++;
      if (dout !== exp[i]) begin failures++; $display("FAIL ovl_dout bit%0d: got %b want %b", 11 - i, dout, exp[i]); end
    end
    checks++; if (match_cnt !== 16'd3) begin failures++; $display("FAIL ovl_cnt: got %0d want 3", match_cnt); end
  endtask

  task automatic test_non_overlap();
    logic [10:0] bits = 11'b11011011011;
    logic [10:0] exp  = 11'b00001000001;
    cnt_clr = 1'b1;
    do_cfg(8'h1B, LW'(5), 1'b0, 1'b0, 1'b0);
    cnt_clr = 1'b0;
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL novl_cfg_err: got %b want 0", cfg_err); end
    checks++; if (match_cnt !== 16'd0) begin failures++; $display("FAIL novl_clr: got %0d want 0", match_cnt); end
    for (int i = 10; i >= 0; i--) begin
      step(bits[i], 1'b1);
      checks++;
      if (dout !== exp[i]) begin failures++; $display("FAIL novl_dout bit%0d: got %b want %b", 11 - i, dout, exp[i]); end
    end
    checks++; if (match_cnt !== 16'd2) begin failures++; $display("FAIL novl_cnt: got %0d want 2", match_cnt); end
  endtask

  task automatic test_gaps_and_reset();
    // {din, valid, expected dout} per cycle
    logic [2:0] vec [8] = '{3'b110, 3'b110, 3'b100, 3'b100, 3'b100, 3'b010, 3'b110, 3'b111};
    logic [3:0] tail = 4'b1101;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(vec[i][2], vec[i][1]);
      checks++;
      if (dout !== vec[i][0]) begin failures++; $display("FAIL gap_dout cyc%0d: got %b want %b", i, dout, vec[i][0]); end
    end
    for (int i = 3; i >= 0; i--) begin
      step(tail[i], 1'b1);
      checks++;
      if (dout !== 1'b0) begin failures++; $display("FAIL tail_dout bit%0d: got %b want 0", 4 - i, dout); end
    end
    do_reset();
    step(1'b1, 1'b1);
    checks++; if (dout !== 1'b0) begin failures++; $display("FAIL rst_mid_dout: got %b want 0", dout); end
    checks++; if (match_cnt !== 16'd0) begin failures++; $display("FAIL rst_mid_cnt: got %0d want 0", match_cnt); end
  endtask

  task automatic test_reprogram();
    logic [4:0] bits = 5'b10101;
    logic [4:0] exp  = 5'b00101;
    do_cfg(8'b0000_0101, LW'(3), 1'b1, 1'b0, 1'b0);
    for (int i = 4; i >= 0; i--) begin
      step(bits[i], 1'b1);
      checks++;
      if (dout !== exp[i]) begin failures++; $display("FAIL rp_dout bit%0d: got %b want %b", 5 - i, dout, exp[i]); end
    end
    // Rejected length 0 with a valid 0: the bit still enters history.
    do_cfg(8'hFF, LW'(0), 1'b0, 1'b0, 1'b1);
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL len0_err: got %b want 1", cfg_err); end
    checks++; if (dout !== 1'b0) begin failures++; $display("FAIL len0_dout: got %b want 0", dout); end
    step(1'b1, 1'b1);
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL len0_err_clr: got %b want 0", cfg_err); end
    checks++; if (dout !== 1'b1) begin failures++; $display("FAIL len0_keep: got %b want 1", dout); end
    do_cfg(8'hFF, LW'(9), 1'b0, 1'b0, 1'b0);
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL len9_err: got %b want 1", cfg_err); end
    step(1'b0, 1'b1);
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL len9_err_clr: got %b want 0", cfg_err); end
    checks++; if (dout !== 1'b0) begin failures++; $display("FAIL len9_d0: got %b want 0", dout); end
    step(1'b1, 1'b1);
    checks++; if (dout !== 1'b1) begin failures++; $display("FAIL len9_keep: got %b want 1", dout); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp = 4'b0111;
    do_cfg(8'b0000_0011, LW'(2), 1'b1, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, 1'b1);
      checks++;
      if (dout !== exp[i]) begin failures++; $display("FAIL b2b_dout bit%0d: got %b want %b", 4 - i, dout, exp[i]); end
    end
  endtask

  task automatic test_counter_sat();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    do_cfg(8'b0000_0001, LW'(1), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if (match_cnt_c !== exp_cnt[i]) begin failures++; $display("FAIL sat_cnt m%0d: got %0d want %0d", i + 1, match_cnt_c, exp_cnt[i]); end
    end
    step(1'b0, 1'b1);
    checks++; if (dout_c !== 1'b0) begin failures++; $display("FAIL len1_zero: got %b want 0", dout_c); end
    cnt_clr = 1'b1;
    step(1'b1, 1'b1);
    checks++; if (match_cnt_c !== 2'd1) begin failures++; $display("FAIL clr_match: got %0d want 1", match_cnt_c); end
    checks++; if (dout_c !== 1'b1) begin failures++; $display("FAIL clr_match_dout: got %b want 1", dout_c); end
    step(1'b1, 1'b0);
    cnt_clr = 1'b0;
    checks++; if (match_cnt_c !== 2'd0) begin failures++; $display("FAIL clr_alone: got %0d want 0", match_cnt_c); end
  endtask

  task automatic test_cfg_with_valid();
    logic [3:0] pre  = 4'b1101;
    logic [4:0] bits = 5'b11011;
    logic [4:0] exp  = 5'b00001;
    do_reset();
    for (int i = 3; i >= 0; i--) step(pre[i], 1'b1);
    do_cfg(8'h1B, LW'(5), 1'b1, 1'b1, 1'b1);
    checks++; if (dout !== 1'b0) begin failures++; $display("FAIL cfgv_dout: got %b want 0", dout); end
    checks++; if (match_cnt !== 16'd0) begin failures++; $display("FAIL cfgv_cnt: got %0d want 0", match_cnt); end
    for (int i = 4; i >= 0; i--) begin
      step(bits[i], 1'b1);
      checks++;
      if (dout !== exp[i]) begin failures++; $display("FAIL cfgv_after bit%0d: got %b want %b", 5 - i, dout, exp[i]); end
    end
    checks++; if (match_cnt !== 16'd1) begin failures++; $display("FAIL cfgv_cnt_end: got %0d want 1", match_cnt); end
  endtask

  initial begin
    test_reset();
    test_default_overlap();
    test_non_overlap();
    test_gaps_and_reset();
    test_reprogram();
    test_back_to_back();
    test_counter_sat();
    test_cfg_with_valid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
